// File: rtl/ctrl_sequencer_if.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer_if
// Data-bus handshake between the control sequencer and the data memory port.
//   dbus_req : request, driven by the sequencer while it sits in MEM
//   dbus_ack : completion, driven by the bus/memory side
// Modports:
//   master : sequencer side (drives req, samples ack)
//   slave  : bus side       (samples req, drives ack)
// ---------------------------------------------------------------------------
interface ctrl_sequencer_if;
  logic dbus_req;
  logic dbus_ack;

  modport master (output dbus_req, input dbus_ack);
  modport slave  (input dbus_req, output dbus_ack);
endinterface

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
// Multi-cycle control sequencer for the RV32I core: fetch with configurable
// wait states, optional data-memory phase with req/ack handshake and
// timeout, register writeback strobes and a sticky trap.
//
// Optional feature macro: CTRL_SEQ_INSTRET_EN
//   defined   -> o_instret counts enable_pc_counter pulses (wraps mod 2^CNT_W)
//   undefined -> o_instret is constant 0, no counter logic
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_opcode[6:0]         IR opcode field (valid from EXEC onward)
//   i_stall               freeze request
//   dbus (master)         dbus_req out / dbus_ack in
//   o_en_iaddr            PC onto instruction address bus
//   o_load_ir             IR load strobe
//   o_enable_pc_counter   PC advance, one pulse per retired instruction
//   o_reg_we              register-file write strobe
//   o_trap, o_trap_cause  sticky trap and cause (1 illegal, 2 bus timeout)
//   o_state[2:0]          current state for debug
//   o_instret[CNT_W-1:0]  retired-instruction count
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
  parameter int unsigned FETCH_WAIT  = 0,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_opcode,
  input  logic             i_stall,
  ctrl_sequencer_if.master dbus,
  output logic             o_en_iaddr,
  output logic             o_load_ir,
  output logic             o_enable_pc_counter,
  output logic             o_reg_we,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_instret
);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_ADDR_OUT   = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_LOAD_IR    = 3'd3,
    ST_EXEC       = 3'd4,
    ST_MEM        = 3'd5,
    ST_TRAP       = 3'd6
  } state_t;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // Terminal counter values; the ternaries keep a zero parameter from wrapping.
  localparam bit         FW_EN    = (FETCH_WAIT > 0);
  localparam bit         TMO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [3:0] FW_LAST  = FW_EN  ? 4'(FETCH_WAIT - 1)  : 4'd0;
  localparam logic [7:0] TMO_LAST = TMO_EN ? 8'(MEM_TIMEOUT - 1) : 8'd0;

  function automatic logic f_is_legal(input logic [6:0] op);
    case (op)
      OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: f_is_legal = 1'b1;
      default:                           f_is_legal = 1'b0;
    endcase
  endfunction

  // Opcodes that retire in EXEC with a destination-register write.
  function automatic logic f_writes_rd(input logic [6:0] op);
    case (op)
      OP_ALU, OP_ALUI, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: f_writes_rd = 1'b1;
      default:                                            f_writes_rd = 1'b0;
    endcase
  endfunction

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_wait_cnt;
  logic [7:0] r_tmo_cnt;
  logic       r_is_load;
  logic       r_trap;
  logic [1:0] r_trap_cause;
  logic       w_trap_set;
  logic [1:0] w_trap_cause;
  logic       w_legal;
  logic       w_is_mem;
  logic       w_en_iaddr;
  logic       w_load_ir;
  logic       w_pc_en;
  logic       w_reg_we;
  logic       w_dbus_req;

  assign w_legal  = f_is_legal(i_opcode);
  assign w_is_mem = (i_opcode == OP_LOAD) || (i_opcode == OP_STORE);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_RESET;
    else       r_state <= w_next_state;
  end

  // Next-state and trap-entry decode
  always_comb begin
    w_next_state = r_state;
    w_trap_set   = 1'b0;
    w_trap_cause = 2'd0;
    case (r_state)
      ST_RESET: begin
        if (!i_stall) w_next_state = ST_ADDR_OUT;
        else          w_next_state = r_state;
      end
      ST_ADDR_OUT: begin
        if (!i_stall) w_next_state = FW_EN ? ST_FETCH_WAIT : ST_LOAD_IR;
        else          w_next_state = r_state;
      end
      ST_FETCH_WAIT: begin
        if (!i_stall && (r_wait_cnt == FW_LAST)) w_next_state = ST_LOAD_IR;
        else                                     w_next_state = r_state;
      end
      ST_LOAD_IR: begin
        if (!i_stall) w_next_state = ST_EXEC;
        else          w_next_state = r_state;
      end
      ST_EXEC: begin
        if (i_stall) begin
          w_next_state = r_state;
        end else if (!w_legal) begin
          w_next_state = ST_TRAP;
          w_trap_set   = 1'b1;
          w_trap_cause = CAUSE_ILLEGAL;
        end else if (w_is_mem) begin
          w_next_state = ST_MEM;
        end else begin
          w_next_state = ST_ADDR_OUT;
        end
      end
      ST_MEM: begin
        // Ack beats both stall and a simultaneous timeout.
        if (dbus.dbus_ack) begin
          w_next_state = ST_ADDR_OUT;
        end else if (TMO_EN && !i_stall && (r_tmo_cnt == TMO_LAST)) begin
          w_next_state = ST_TRAP;
          w_trap_set   = 1'b1;
          w_trap_cause = CAUSE_TIMEOUT;
        end else begin
          w_next_state = r_state;
        end
      end
      ST_TRAP: w_next_state = ST_TRAP;
      default: w_next_state = ST_RESET;
    endcase
  end

  // Fetch wait and MEM timeout counters; both restart on entry to their state.
  // The timeout counter saturates so an unlimited wait never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= 4'd0;
      r_tmo_cnt  <= 8'd0;
    end else begin
      if (w_next_state != ST_FETCH_WAIT)
        r_wait_cnt <= 4'd0;
      else if ((r_state == ST_FETCH_WAIT) && !i_stall)
        r_wait_cnt <= r_wait_cnt + 4'd1;
      else
        r_wait_cnt <= r_wait_cnt;

      if (w_next_state != ST_MEM)
        r_tmo_cnt <= 8'd0;
      else if ((r_state == ST_MEM) && !i_stall && (r_tmo_cnt != 8'hFF))
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      else
        r_tmo_cnt <= r_tmo_cnt;
    end
  end

  // Remember whether the memory access is a load (gates writeback on ack)
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_is_load <= 1'b0;
    else if ((r_state == ST_EXEC) && !i_stall && w_legal && w_is_mem)
      r_is_load <= (i_opcode == OP_LOAD);
    else
      r_is_load <= r_is_load;
  end

  // Sticky trap flag and cause
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_trap       <= 1'b0;
      r_trap_cause <= 2'd0;
    end else if (w_trap_set) begin
      r_trap       <= 1'b1;
      r_trap_cause <= w_trap_cause;
    end else begin
      r_trap       <= r_trap;
      r_trap_cause <= r_trap_cause;
    end
  end

  // Strobe decode; everything is held low while reset is asserted.
  always_comb begin
    w_en_iaddr = 1'b0;
    w_load_ir  = 1'b0;
    w_pc_en    = 1'b0;
    w_reg_we   = 1'b0;
    w_dbus_req = 1'b0;
    if (!i_rst) begin
      w_en_iaddr = (r_state == ST_ADDR_OUT) || (r_state == ST_FETCH_WAIT) ||
                   (r_state == ST_LOAD_IR);
      w_load_ir  = (r_state == ST_LOAD_IR) && !i_stall;
      w_dbus_req = (r_state == ST_MEM);
      w_pc_en    = ((r_state == ST_EXEC) && w_legal && !w_is_mem && !i_stall) ||
                   ((r_state == ST_MEM) && dbus.dbus_ack);
      w_reg_we   = ((r_state == ST_EXEC) && f_writes_rd(i_opcode) && !i_stall) ||
                   ((r_state == ST_MEM) && dbus.dbus_ack && r_is_load);
    end else begin
      w_en_iaddr = 1'b0;
    end
  end

`ifdef CTRL_SEQ_INSTRET_EN
  logic [CNT_W-1:0] r_instret;

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_instret <= {CNT_W{1'b0}};
    else if (w_pc_en) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
    else              r_instret <= r_instret;
  end

  assign o_instret = r_instret;
`else
  assign o_instret = {CNT_W{1'b0}};
`endif

  assign o_en_iaddr          = w_en_iaddr;
  assign o_load_ir           = w_load_ir;
  assign o_enable_pc_counter = w_pc_en;
  assign o_reg_we            = w_reg_we;
  assign dbus.dbus_req       = w_dbus_req;
  assign o_trap              = r_trap;
  assign o_trap_cause        = r_trap_cause;
  assign o_state             = r_state;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ctrl_sequencer
// Directed bench for ctrl_sequencer. Two instances share the stimulus:
//   u_a : FETCH_WAIT=0, MEM_TIMEOUT=4,  CNT_W=32
//   u_b : FETCH_WAIT=2, MEM_TIMEOUT=16, CNT_W=4
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_ctrl_sequencer;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       stall;
  logic       ack;

  logic        a_en_iaddr, a_load_ir, a_pc_en, a_reg_we, a_trap;
  logic [1:0]  a_cause;
  logic [2:0]  a_state;
  logic [31:0] a_instret;
  logic        b_en_iaddr, b_load_ir, b_pc_en, b_reg_we, b_trap;
  logic [1:0]  b_cause;
  logic [2:0]  b_state;
  logic [3:0]  b_instret;

  int n_checks = 0;
  int n_errors = 0;

  ctrl_sequencer_if if_a();
  ctrl_sequencer_if if_b();
  assign if_a.dbus_ack = ack;
  assign if_b.dbus_ack = ack;

  always #5 clk = ~clk;

  ctrl_sequencer #(.FETCH_WAIT(0), .MEM_TIMEOUT(4), .CNT_W(32)) u_a (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_stall(stall), .dbus(if_a),
    .o_en_iaddr(a_en_iaddr), .o_load_ir(a_load_ir), .o_enable_pc_counter(a_pc_en),
    .o_reg_we(a_reg_we), .o_trap(a_trap), .o_trap_cause(a_cause),
    .o_state(a_state), .o_instret(a_instret)
  );

  ctrl_sequencer #(.FETCH_WAIT(2), .MEM_TIMEOUT(16), .CNT_W(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_stall(stall), .dbus(if_b),
    .o_en_iaddr(b_en_iaddr), .o_load_ir(b_load_ir), .o_enable_pc_counter(b_pc_en),
    .o_reg_we(b_reg_we), .o_trap(b_trap), .o_trap_cause(b_cause),
    .o_state(b_state), .o_instret(b_instret)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Synchronous reset, released so that the next edge enters ADDR_OUT.
  task automatic do_reset(input logic [6:0] op);
    rst = 1'b1; opcode = op; stall = 1'b0; ack = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = OP_ALU; stall = 1'b0; ack = 1'b0;
    cyc(); cyc(); #1;
    n_checks++; if (a_state !== 3'd0) begin n_errors++; $display("FAIL reset_state_a: got %0d expected 0", a_state); end
    n_checks++; if (b_state !== 3'd0) begin n_errors++; $display("FAIL reset_state_b: got %0d expected 0", b_state); end
    n_checks++; if ({a_trap, a_cause, b_trap, b_cause} !== 6'd0) begin n_errors++; $display("FAIL reset_trap: got %b expected 000000", {a_trap, a_cause, b_trap, b_cause}); end
    n_checks++; if ({a_en_iaddr, a_load_ir, a_pc_en, a_reg_we, if_a.dbus_req} !== 5'd0) begin n_errors++; $display("FAIL reset_strobes: got %b expected 00000", {a_en_iaddr, a_load_ir, a_pc_en, a_reg_we, if_a.dbus_req}); end
    n_checks++; if ((a_instret !== 32'd0) || (b_instret !== 4'd0)) begin n_errors++; $display("FAIL reset_instret: got %0d/%0d expected 0/0", a_instret, b_instret); end
    rst = 1'b0;
    cyc(); cyc(); cyc(); #1;
    n_checks++; if ((a_state !== 3'd4) || (a_pc_en !== 1'b1)) begin n_errors++; $display("FAIL pre_reset_exec: got state %0d pc_en %b expected 4/1", a_state, a_pc_en); end
    // Reset asserted mid-instruction: EXEC strobes must drop immediately.
    rst = 1'b1; #1;
    n_checks++; if ({a_pc_en, a_reg_we} !== 2'b00) begin n_errors++; $display("FAIL midreset_strobes: got %b expected 00", {a_pc_en, a_reg_we}); end
    cyc(); #1;
    n_checks++; if ((a_state !== 3'd0) || (b_state !== 3'd0)) begin n_errors++; $display("FAIL midreset_state: got %0d/%0d expected 0/0", a_state, b_state); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    logic [2:0] exp_st;
    do_reset(OP_ALU);
    for (int i = 0; i < 9; i++) begin
      cyc(); #1;
      exp_st = (i % 3 == 0) ? 3'd1 : ((i % 3 == 1) ? 3'd3 : 3'd4);
      n_checks++; if (a_state !== exp_st) begin n_errors++; $display("FAIL alu_state[%0d]: got %0d expected %0d", i, a_state, exp_st); end
      n_checks++; if (a_pc_en !== (i % 3 == 2)) begin n_errors++; $display("FAIL alu_pc_en[%0d]: got %b expected %b", i, a_pc_en, (i % 3 == 2)); end
      n_checks++; if (a_reg_we !== (i % 3 == 2)) begin n_errors++; $display("FAIL alu_reg_we[%0d]: got %b expected %b", i, a_reg_we, (i % 3 == 2)); end
      n_checks++; if (a_load_ir !== (i % 3 == 1)) begin n_errors++; $display("FAIL alu_load_ir[%0d]: got %b expected %b", i, a_load_ir, (i % 3 == 1)); end
    end
  endtask

  task automatic test_fetch_wait();
    logic [2:0] exp_st;
    int         k;
    do_reset(OP_BRANCH);
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      k = i % 5;
      case (k)
        0:       exp_st = 3'd1;
        1, 2:    exp_st = 3'd2;
        3:       exp_st = 3'd3;
        default: exp_st = 3'd4;
      endcase
      n_checks++; if (b_state !== exp_st) begin n_errors++; $display("FAIL fw_state[%0d]: got %0d expected %0d", i, b_state, exp_st); end
      n_checks++; if (b_en_iaddr !== (k != 4)) begin n_errors++; $display("FAIL fw_en_iaddr[%0d]: got %b expected %b", i, b_en_iaddr, (k != 4)); end
      n_checks++; if (b_pc_en !== (k == 4)) begin n_errors++; $display("FAIL fw_pc_en[%0d]: got %b expected %b", i, b_pc_en, (k == 4)); end
      n_checks++; if (b_reg_we !== 1'b0) begin n_errors++; $display("FAIL fw_reg_we[%0d]: got %b expected 0", i, b_reg_we); end
      n_checks++; if (b_load_ir !== (k == 3)) begin n_errors++; $display("FAIL fw_load_ir[%0d]: got %b expected %b", i, b_load_ir, (k == 3)); end
    end
  endtask

  task automatic test_load();
    logic [2:0] exp_st;
    int         req_cycles;
    req_cycles = 0;
    do_reset(OP_LOAD);
    for (int i = 0; i < 7; i++) begin
      cyc();
      ack = (i == 5);
      #1;
      case (i)
        0, 6:    exp_st = 3'd1;
        1:       exp_st = 3'd3;
        2:       exp_st = 3'd4;
        default: exp_st = 3'd5;
      endcase
      if (if_a.dbus_req === 1'b1) req_cycles++;
      n_checks++; if (a_state !== exp_st) begin n_errors++; $display("FAIL load_state[%0d]: got %0d expected %0d", i, a_state, exp_st); end
      n_checks++; if (a_pc_en !== (i == 5)) begin n_errors++; $display("FAIL load_pc_en[%0d]: got %b expected %b", i, a_pc_en, (i == 5)); end
      n_checks++; if (a_reg_we !== (i == 5)) begin n_errors++; $display("FAIL load_reg_we[%0d]: got %b expected %b", i, a_reg_we, (i == 5)); end
    end
    ack = 1'b0;
    n_checks++; if (req_cycles != 3) begin n_errors++; $display("FAIL load_req_cycles: got %0d expected 3", req_cycles); end
  endtask

  task automatic test_timeout();
    logic [2:0] exp_st;
    do_reset(OP_STORE);
    for (int i = 0; i < 27; i++) begin
      cyc(); #1;
      if (i == 0)      exp_st = 3'd1;
      else if (i == 1) exp_st = 3'd3;
      else if (i == 2) exp_st = 3'd4;
      else if (i < 7)  exp_st = 3'd5;
      else             exp_st = 3'd6;
      n_checks++; if (a_state !== exp_st) begin n_errors++; $display("FAIL tmo_state[%0d]: got %0d expected %0d", i, a_state, exp_st); end
      n_checks++; if (a_trap !== (i >= 7)) begin n_errors++; $display("FAIL tmo_trap[%0d]: got %b expected %b", i, a_trap, (i >= 7)); end
      n_checks++; if (a_cause !== ((i >= 7) ? 2'd2 : 2'd0)) begin n_errors++; $display("FAIL tmo_cause[%0d]: got %0d expected %0d", i, a_cause, (i >= 7) ? 2 : 0); end
      n_checks++; if (if_a.dbus_req !== ((i >= 3) && (i < 7))) begin n_errors++; $display("FAIL tmo_req[%0d]: got %b expected %b", i, if_a.dbus_req, ((i >= 3) && (i < 7))); end
      n_checks++; if ({a_pc_en, a_reg_we, a_en_iaddr && (i >= 7)} !== 3'b000) begin n_errors++; $display("FAIL tmo_strobes[%0d]: got %b expected 000", i, {a_pc_en, a_reg_we, a_en_iaddr && (i >= 7)}); end
    end
    rst = 1'b1;
    cyc(); #1;
    n_checks++; if ({a_trap, a_cause, a_state} !== 6'd0) begin n_errors++; $display("FAIL tmo_clear: got trap %b cause %0d state %0d expected 0/0/0", a_trap, a_cause, a_state); end
    rst = 1'b0;
  endtask

  task automatic test_illegal();
    logic [2:0] exp_st;
    do_reset(OP_BAD);
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      exp_st = (i == 0) ? 3'd1 : ((i == 1) ? 3'd3 : ((i == 2) ? 3'd4 : 3'd6));
      n_checks++; if (a_state !== exp_st) begin n_errors++; $display("FAIL ill_state[%0d]: got %0d expected %0d", i, a_state, exp_st); end
      n_checks++; if ({a_pc_en, a_reg_we} !== 2'b00) begin n_errors++; $display("FAIL ill_strobes[%0d]: got %b expected 00", i, {a_pc_en, a_reg_we}); end
      n_checks++; if ({a_trap, a_cause} !== ((i >= 3) ? 3'b101 : 3'b000)) begin n_errors++; $display("FAIL ill_trap[%0d]: got %b expected %b", i, {a_trap, a_cause}, (i >= 3) ? 3'b101 : 3'b000); end
    end
  endtask

  task automatic test_stall();
    do_reset(OP_ALU);
    cyc();
    stall = 1'b1; #1;
    n_checks++; if ((a_state !== 3'd1) || (a_en_iaddr !== 1'b1)) begin n_errors++; $display("FAIL stall_addr: got state %0d en_iaddr %b expected 1/1", a_state, a_en_iaddr); end
    cyc(); #1;
    n_checks++; if (a_state !== 3'd1) begin n_errors++; $display("FAIL stall_addr_hold: got %0d expected 1", a_state); end
    stall = 1'b0;
    cyc(); #1;
    n_checks++; if (a_state !== 3'd3) begin n_errors++; $display("FAIL stall_loadir: got %0d expected 3", a_state); end
    cyc();
    stall = 1'b1; #1;
    n_checks++; if ({a_state, a_pc_en, a_reg_we, a_load_ir} !== {3'd4, 3'b000}) begin n_errors++; $display("FAIL stall_exec1: got %0d/%b%b%b expected 4/000", a_state, a_pc_en, a_reg_we, a_load_ir); end
    cyc(); #1;
    n_checks++; if ({a_state, a_pc_en, a_reg_we} !== {3'd4, 2'b00}) begin n_errors++; $display("FAIL stall_exec2: got %0d/%b%b expected 4/00", a_state, a_pc_en, a_reg_we); end
    cyc();
    stall = 1'b0; #1;
    n_checks++; if ({a_state, a_pc_en, a_reg_we} !== {3'd4, 2'b11}) begin n_errors++; $display("FAIL stall_release: got %0d/%b%b expected 4/11", a_state, a_pc_en, a_reg_we); end
    cyc(); #1;
    n_checks++; if (a_state !== 3'd1) begin n_errors++; $display("FAIL stall_next: got %0d expected 1", a_state); end
  endtask

  task automatic test_instret();
    do_reset(OP_ALU);
    for (int i = 0; i < 86; i++) begin
      cyc(); #1;
`ifdef CTRL_SEQ_INSTRET_EN
      if (i == 30) begin
        n_checks++; if (a_instret !== 32'd10) begin n_errors++; $display("FAIL instret_a: got %0d expected 10", a_instret); end
      end
      if (i == 85) begin
        n_checks++; if (b_instret !== 4'd1) begin n_errors++; $display("FAIL instret_b_wrap: got %0d expected 1", b_instret); end
      end
`else
      if ((i == 30) || (i == 85)) begin
        n_checks++; if ((a_instret !== 32'd0) || (b_instret !== 4'd0)) begin n_errors++; $display("FAIL instret_tied: got %0d/%0d expected 0/0", a_instret, b_instret); end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_fetch_wait();
    test_load();
    test_timeout();
    test_illegal();
    test_stall();
    test_instret();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
